// File: rtl/lfsr_arbiter_if.sv
// Bundle of the request/delivery and generator-control signals around lfsr_arbiter.
// master: arbiter side; slave: requesters plus generator side.
interface lfsr_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [3:0]         prn;
    logic               lfsr_enable;
    logic [NUM_REQ-1:0] rnd_valid;
    logic [3:0]         rnd_data;
    logic [IW-1:0]      gnt_id;
    logic               busy;

    modport master (
        input  req, prn,
        output lfsr_enable, rnd_valid, rnd_data, gnt_id, busy
    );

    modport slave (
        output req, prn,
        input  lfsr_enable, rnd_valid, rnd_data, gnt_id, busy
    );
endinterface

// File: rtl/lfsr_arbiter.sv
// Round-robin scheduler sharing one 4-bit Fibonacci LFSR among NUM_REQ requesters.
// One draw at a time: pulse enable, let prn settle, capture and strobe the winner.
module lfsr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WARMUP  = 4,
    parameter int SETTLE  = 2
) (
    input logic            clk,
    input logic            reset,
    lfsr_arbiter_if.master bus
);
    localparam int IW      = $clog2(NUM_REQ);
    localparam int CNT_MAX = (WARMUP > SETTLE) ? WARMUP : SETTLE;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] WARM_LAST   = CW'(WARMUP);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [IW-1:0] LAST_ID     = IW'(NUM_REQ - 1);
    localparam logic [IW:0]   NUM_WIDE    = (IW+1)'(NUM_REQ);

    typedef enum logic [2:0] {
        S_WARMUP,
        S_IDLE,
        S_PULSE,
        S_WAIT,
        S_DELIVER
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [IW-1:0]      ptr;
    logic               lfsr_enable_q;
    logic [NUM_REQ-1:0] rnd_valid_q;
    logic [3:0]         rnd_data_q;
    logic [IW-1:0]      gnt_id_q;

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IW:0]          sum;
    logic [IW-1:0]        winner;
    logic                 any_req;

    // Rotate so that bit 0 is the pointer position; descending scan leaves
    // the lowest set rotated bit (first in round-robin order) as the winner.
    always_comb begin
        req_dbl = {bus.req, bus.req};
        req_rot = req_dbl[ptr +: NUM_REQ];
        any_req = |bus.req;
        sum     = '0;
        winner  = '0;
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            if (req_rot[i-1]) begin
                sum    = {1'b0, ptr} + (IW+1)'(i - 1);
                winner = (sum >= NUM_WIDE) ? IW'(sum - NUM_WIDE) : IW'(sum);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_WARMUP;
            cnt           <= '0;
            ptr           <= '0;
            lfsr_enable_q <= 1'b0;
            rnd_valid_q   <= '0;
            rnd_data_q    <= '0;
            gnt_id_q      <= '0;
        end else begin
            lfsr_enable_q <= 1'b0;
            rnd_valid_q   <= '0;
            case (state)
                S_WARMUP: begin
                    if (cnt == WARM_LAST) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (any_req) begin
                        gnt_id_q      <= winner;
                        lfsr_enable_q <= 1'b1;
                        state         <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == SETTLE_LAST) begin
                        rnd_data_q  <= bus.prn;
                        rnd_valid_q <= NUM_REQ'(1) << gnt_id_q;
                        state       <= S_DELIVER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DELIVER: begin
                    ptr   <= (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= S_WARMUP;
                end
            endcase
        end
    end

    assign bus.lfsr_enable = lfsr_enable_q;
    assign bus.rnd_valid   = rnd_valid_q;
    assign bus.rnd_data    = rnd_data_q;
    assign bus.gnt_id      = gnt_id_q;
    assign bus.busy        = (state != S_IDLE);
endmodule

// File: doc/lfsr_arbiter.md
# lfsr_arbiter

Round-robin scheduler that shares one 4-bit Fibonacci pseudo-random generator (`fibonacci_lfsr`) among `NUM_REQ` requesters. After reset it waits for the generator to load its seed. It then serves one request at a time: it pulses the generator's `lfsr_enable`, waits for the shifted value to settle, and returns that value to the granted requester with a one-cycle valid strobe. It sits between the generator and its consumers, and it is the only block allowed to drive `lfsr_enable`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WARMUP`, 4: cycles after reset release before the first grant. Must be ≥ 4, the generator's seed-load time.
- `SETTLE`, 2: wait cycles after the enable pulse before `prn` is captured. Must be ≥ 2.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high. Also drives the generator's reset, so it must be held across at least one `clk` edge.
- `req`, in, `NUM_REQ`: level request per requester, held high until its `rnd_valid` bit.
- `prn`, in, 4: generator output.
- `lfsr_enable`, out, 1: one-cycle shift pulse to the generator. Reset value 0.
- `rnd_valid`, out, `NUM_REQ`: one-hot delivery strobe. Reset value 0.
- `rnd_data`, out, 4: captured random value, held until the next capture. Reset value 4'h0.
- `gnt_id`, out, `$clog2(NUM_REQ)`: index of the current/last grant. Reset value 0.
- `busy`, out, 1: high in every state except IDLE. Reset value 1.

## Operation
- FSM states:
  - WARMUP: counts `WARMUP` cycles, then goes to IDLE. All `req` are ignored.
  - IDLE: if any `req` bit is high, select a winner, register `gnt_id`, and go to PULSE. Otherwise stay in IDLE.
  - PULSE: `lfsr_enable`=1 for exactly this cycle. Next state WAIT.
  - WAIT: stays for `SETTLE` cycles. At the end of the last cycle, `rnd_data` <= `prn`. Next state DELIVER.
  - DELIVER: `rnd_valid[gnt_id]`=1, pointer <= (`gnt_id`+1) mod `NUM_REQ`. Next state IDLE.
- Illegal state encodings go to WARMUP.
- Arbitration:
  - Round-robin pointer `ptr`, reset value 0.
  - Winner = first set `req` bit scanning `ptr`, `ptr`+1, … with wrap from `NUM_REQ`-1 to 0.
- Requests are sampled only in IDLE. A `req` deasserted after the grant does not cancel the draw; the value is still delivered and is discarded by the requester.
- A requester holding `req` through DELIVER is seen again in the following IDLE, subject to round-robin order.
- Generator contract:
  - Enable sampled high while the generator is idle → `prn` <= {`prn[2:0]`, `prn[3]`^`prn[1]`} one cycle later.
  - Seed 4'h3. Cycle from seed: 7, F, E, C, 9, 3, with period 6.
- Reset (asserted at any time, including mid-draw):
  - All outputs go immediately to their reset values, `ptr` returns to 0, and the state returns to WARMUP.
  - An in-flight draw is dropped: no `rnd_valid` is issued for it.

## Timing
- `req` seen in IDLE at cycle t → `lfsr_enable` high at t+1 → WAIT at t+2..t+1+`SETTLE` → `rnd_valid` at t+2+`SETTLE` (t+4 with defaults) → IDLE at t+5.
- Peak throughput: one draw per `SETTLE`+3 cycles. `lfsr_enable` is never high on two cycles closer than that.
- First IDLE cycle is `WARMUP` cycles after the first edge with `reset` low.
- All outputs are registered except `busy`, which is decoded from the state.
- `rnd_valid` and `lfsr_enable` are never high in the same cycle.

## Test plan
- Reset release, `req`=4'b0100 from cycle 0:
  - No grant during WARMUP.
  - `rnd_valid`=4'b0100 with `rnd_data`=4'h7 at t+4 after the first IDLE.
  - `gnt_id`=2.
- `req`=4'b1111 held continuously after warmup:
  - Grants in order 0, 1, 2, 3, 0 with data 7, F, E, C, 9.
  - `ptr` wraps from 3 to 0.
  - Successive `rnd_valid` pulses are exactly 5 cycles apart.
- Six single-requester draws on `req[1]`:
  - Data 7, F, E, C, 9, 3.
  - Seventh draw returns 7, confirming period 6.
- `req[3]` raised during PULSE while `req[0]` is being served:
  - `req[0]` is delivered first.
  - `req[3]` is granted in the next IDLE and `busy` drops only between the draws.
- `reset` asserted for 1 cycle during WAIT:
  - `lfsr_enable`, `rnd_valid`, `rnd_data`, `gnt_id` go to 0 and `busy` goes to 1 asynchronously.
  - No strobe is issued for the dropped draw.
  - After warmup, the next draw returns 4'h7 to requester 0.
- `req[2]` withdrawn during WAIT:
  - `rnd_valid`=4'b0100 is still issued.
  - The next grant with `req`=4'b0101 goes to requester 0 (`ptr`=3 wraps).
